// File: rtl/fpm_pkg.sv
// Shared constants and types for the floating-point multiplier slice.
package fpm_pkg;

    // Single-precision field layout, kept here so every client decodes fields the same way.
    localparam int XLEN     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    localparam int EXP_BIAS = 127;

    // Tag id field is sized for up to 256 requesters; users narrow it to their own id width.
    localparam int TAG_IDW  = 8;

    // One issue travelling alongside the multiplier pipeline.
    typedef struct packed {
        logic               valid;
        logic [TAG_IDW-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requesters starting at ptr and picks the first active one.
// Purely combinational; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    int cand;

    // Find the first active requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!any && req[IDW'(cand)]) begin
                any = 1'b1;
                idx = IDW'(cand);
            end
        end
        if (any) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fpm_rr_scheduler.sv
// Shares one pipelined single-precision multiplier among NREQ requesters.
// Round-robin issue of one operand pair per cycle; each issue carries its requester id
// down a tag pipe that matches the multiplier latency, and the product returns with that id.
module fpm_rr_scheduler
    import fpm_pkg::*;
#(
    parameter int XLEN    = fpm_pkg::XLEN,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [XLEN-1:0]      mul_a,
    output logic [XLEN-1:0]      mul_b,
    input  logic [XLEN-1:0]      mul_result,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [XLEN-1:0]      resp_data,
    output logic                 busy
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            any_req;

    // Stage 0 receives the issue; stage MUL_LAT lines up with mul_result.
    tag_t tag_q [MUL_LAT+1];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any_req)
    );

    // Grant is a function of req_valid and ptr only; suppressed while reset is held.
    assign req_ready = grant & {NREQ{~rst}};

    // Capture the granted operand pair and advance the round-robin pointer past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            mul_a <= '0;
            mul_b <= '0;
        end else if (any_req) begin
            // NOTE: registers use non-blocking assignments so all flops sample pre-edge values together.
            mul_a <= req_a[int'(gidx)*XLEN +: XLEN];
            mul_b <= req_b[int'(gidx)*XLEN +: XLEN];
            ptr   <= (int'(gidx) == NREQ-1) ? '0 : gidx + 1'b1;
        end
    end

    // Tag pipe shifts every cycle so ids stay aligned with products through the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the tag pipe is a small register chain, not RAM; every stage is reset so in-flight valids are dropped.
            for (int i = 0; i <= MUL_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= '{valid: any_req, id: TAG_IDW'(gidx)};
            for (int i = 1; i <= MUL_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Register the product and its owner when the tail tag is valid; otherwise hold data and id.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= tag_q[MUL_LAT].valid;
            if (tag_q[MUL_LAT].valid) begin
                resp_id   <= tag_q[MUL_LAT].id[IDW-1:0];
                resp_data <= mul_result;
            end
        end
    end

    // Busy while any issue is still travelling through the tag pipe.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= MUL_LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

endmodule

// File: tb/tb_fpm_rr_scheduler.sv
// Bench for fpm_rr_scheduler: a behavioural pipelined multiplier feeds mul_result, and a
// scoreboard of expected responses (id, product, due cycle) predicts every DUT output.
module tb_fpm_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;
    localparam int W       = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [W-1:0]      mul_result;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              busy;

    always #5 clk = ~clk;

    fpm_rr_scheduler #(
        .XLEN    (W),
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT),
        .IDW     (IDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    // ---------------- behavioural single-precision multiply (normals and zero) ----------------
    function automatic real sp2r(logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) d = {x[31], 63'd0};
        else d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // The double product of two singles is exact, so one round-to-nearest-even step here is correct.
    function automatic logic [31:0] r2sp(real r);
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        logic [28:0] rest;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e    = int'(d[62:52]) - 1023 + 127;
        m    = {2'b01, d[51:29]};
        rest = d[28:0];
        if (rest[28] && ((rest[27:0] != 28'd0) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
        return r2sp(sp2r(a) * sp2r(b));
    endfunction

    // Random normal operand whose exponent keeps every product normal.
    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        return {r[31], 8'($urandom_range(154, 100)), r[22:0]};
    endfunction

    // Multiplier with MUL_LAT register stages from mul_a/mul_b to mul_result.
    logic [W-1:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_result = mpipe[MUL_LAT-1];

    // ---------------- reference model and checking ----------------
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t           sbq[$];
    int             cyc;
    int             mptr;
    logic [31:0]    last_a, last_b, hold_d;
    logic [IDW-1:0] hold_id;
    int             last_g;
    int             resp_count;
    int             checks;
    int             errors;
    logic [NREQ-1:0] pend;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, bit v, logic [31:0] a, logic [31:0] b);
        req_valid[i]     = v;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    // One clock: predict and check the grant, advance the model, then check registered outputs.
    task automatic tick();
        logic [NREQ-1:0] er;
        int g;
        bit exp_v;
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (mptr + k) % NREQ;
            if (g < 0 && req_valid[c]) g = c;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        last_g = g;
        if (g >= 0) begin
            last_a = req_a[g*W +: W];
            last_b = req_b[g*W +: W];
            sbq.push_back('{g, fmul(last_a, last_b), cyc + MUL_LAT + 2});
            mptr = (g + 1) % NREQ;
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_v = 1'b0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            exp_v   = 1'b1;
            hold_id = IDW'(sbq[0].id);
            hold_d  = sbq[0].data;
            void'(sbq.pop_front());
        end
        if (resp_valid === 1'b1) resp_count++;
        check("resp_valid", resp_valid, exp_v);
        check("resp_id", resp_id, hold_id);
        check("resp_data", resp_data, hold_d);
        check("busy", busy, sbq.size() != 0);
        check("mul_a", mul_a, last_a);
        check("mul_b", mul_b, last_b);
    endtask

    // Asynchronous reset taken mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        sbq.delete();
        mptr    = 0;
        last_a  = '0;
        last_b  = '0;
        hold_d  = '0;
        hold_id = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_g[$];
        int n;
        int base;

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        checks = 0;
        errors = 0;
        cyc = 0;
        resp_count = 0;
        last_g = -1;

        // Power-on reset.
        do_reset();

        // 1: single issue from req0, response MUL_LAT+1 edges after accept.
        set_req(0, 1'b1, 32'h404CCCCC, 32'h40866666);
        tick();
        check("t1_grant", last_g, 0);
        req_valid = '0;
        base = resp_count;
        for (int i = 0; i < MUL_LAT + 2; i++) tick();
        check("t1_resp_count", resp_count - base, 1);

        // 2: req2 exact product -0.5 * 6.4.
        set_req(2, 1'b1, 32'hBF000000, 32'h40CCCCCC);
        tick();
        check("t2_grant", last_g, 2);
        req_valid = '0;
        for (int i = 0; i < MUL_LAT + 2; i++) tick();
        check("t2_data", resp_data, 32'hC04CCCCC);
        check("t2_id", resp_id, 2);

        // 3: all requesters held valid from reset rotate 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_fp(), rand_fp());
        exp_g = '{0, 1, 2, 3, 0, 1};
        foreach (exp_g[k]) begin
            tick();
            check("t3_grant", last_g, exp_g[k]);
            if (last_g >= 0) set_req(last_g, 1'b1, rand_fp(), rand_fp());
        end
        req_valid = '0;
        for (int i = 0; i < MUL_LAT + 2; i++) tick();

        // 4: only req1 and req3 active from ptr=0 alternate 1,3,1,3.
        do_reset();
        set_req(1, 1'b1, rand_fp(), rand_fp());
        set_req(3, 1'b1, rand_fp(), rand_fp());
        exp_g = '{1, 3, 1, 3};
        foreach (exp_g[k]) begin
            tick();
            check("t4_grant", last_g, exp_g[k]);
            if (last_g >= 0) set_req(last_g, 1'b1, rand_fp(), rand_fp());
        end
        req_valid = '0;
        for (int i = 0; i < MUL_LAT + 2; i++) tick();

        // 5: req0 streams five pairs with a two-cycle gap; busy falls MUL_LAT+2 cycles after last accept.
        base = resp_count;
        for (int i = 0; i < 7; i++) begin
            if (i == 3 || i == 4) req_valid[0] = 1'b0;
            else set_req(0, 1'b1, rand_fp(), rand_fp());
            tick();
        end
        req_valid = '0;
        n = 1;
        while (busy === 1'b1 && n < 12) begin
            tick();
            n++;
        end
        check("t5_busy_fall", n, MUL_LAT + 2);
        tick();
        check("t5_resp_count", resp_count - base, 5);

        // 6: reset with three issues in flight; nothing returns, next grant goes to req0.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_fp(), rand_fp());
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        req_valid = '0;
        base = resp_count;
        for (int i = 0; i < MUL_LAT + 4; i++) tick();
        check("t6_no_resp", resp_count - base, 0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, rand_fp(), rand_fp());
        tick();
        check("t6_grant", last_g, 0);
        req_valid = '0;
        for (int i = 0; i < MUL_LAT + 2; i++) tick();

        // Random traffic: requesters hold until granted, may drop valid early, re-raise with new pairs.
        pend = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i] = 1'b1;
                    set_req(i, 1'b1, rand_fp(), rand_fp());
                end else if (pend[i] && ($urandom % 10 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            req_valid = pend;
            tick();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        req_valid = '0;
        for (int i = 0; i < MUL_LAT + 3; i++) tick();
        check("drain_empty", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
